// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard controller state encoding and
// architectural constants used across the five-stage pipeline.
package pipe_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        LOADUSE = 3'd2,
        FLUSH   = 3'd3,
        MEMWAIT = 3'd4
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    // addi x0, x0, 0 -- injected into ID/EX as a bubble
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles where inc is high, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, taken-branch redirects,
// data-memory waits, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_taken,
    input  logic             mem_busy,
    output logic             if_adv,
    output logic             if_redirect,
    output logic             if_stall,
    output logic             id_hold,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic             all_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output hz_state_t        dbg_state
);

    // mem_busy acts as an inverted ready: while high the data memory has not
    // completed and every pipeline register must hold; completion is the
    // first cycle it reads low, and the pipeline advances in that same cycle.

    hz_state_t state, state_nxt;
    logic      pend_redir, pend_nxt;
    logic      lu, tk;

    assign lu = ex_valid & ex_is_load & id_valid & (ex_rd != REG_ZERO) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) |
                 (id_use_rs2 & (id_rs2 == ex_rd)));
    assign tk = ex_valid & ex_taken;

    always_comb begin
        if_adv      = 1'b0;
        if_redirect = 1'b0;
        if_stall    = 1'b0;
        id_hold     = 1'b0;
        id_flush    = 1'b0;
        ex_bubble   = 1'b0;
        all_hold    = 1'b0;
        state_nxt   = state;
        pend_nxt    = pend_redir;
        case (state)
            IDLE: begin
                if_stall  = 1'b1;
                all_hold  = 1'b1;
                state_nxt = RUN;
            end
            RUN, LOADUSE: begin
                // LOADUSE outputs equal RUN defaults; new events use RUN rules
                if_adv    = 1'b1;
                state_nxt = RUN;
                if (mem_busy) begin
                    all_hold  = 1'b1;
                    if_adv    = 1'b0;
                    state_nxt = MEMWAIT;
                    if (tk) pend_nxt = 1'b1;
                end else if (tk) begin
                    if_redirect = 1'b1;
                    id_flush    = 1'b1;
                    ex_bubble   = 1'b1;
                    state_nxt   = FLUSH;
                end else if (lu) begin
                    if_adv    = 1'b0;
                    id_hold   = 1'b1;
                    ex_bubble = 1'b1;
                    state_nxt = LOADUSE;
                end
            end
            FLUSH: begin
                if_adv    = 1'b1;
                if_stall  = 1'b1;
                id_flush  = 1'b1;
                state_nxt = RUN;
            end
            MEMWAIT: begin
                if (mem_busy) begin
                    all_hold = 1'b1;
                end else if (pend_redir) begin
                    if_adv      = 1'b1;
                    if_redirect = 1'b1;
                    id_flush    = 1'b1;
                    ex_bubble   = 1'b1;
                    pend_nxt    = 1'b0;
                    state_nxt   = FLUSH;
                end else begin
                    if_adv    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: begin
                if_stall  = 1'b1;
                all_hold  = 1'b1;
                state_nxt = IDLE;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_redir <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_redir <= pend_nxt;
        end
    end

    assign dbg_state = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == LOADUSE) || (state == MEMWAIT)),
        .q     (stall_cnt)
    );

    // Every redirect asserts if_redirect for exactly one cycle
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_redirect),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expected state/outputs
// are queued as stimulus is driven and compared on the falling edge.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // {if_adv, if_redirect, if_stall, id_hold, id_flush, ex_bubble, all_hold}
  localparam logic [6:0] O_IDLE  = 7'b0010001;
  localparam logic [6:0] O_RUN   = 7'b1000000;
  localparam logic [6:0] O_TK    = 7'b1100110;
  localparam logic [6:0] O_LU    = 7'b0001010;
  localparam logic [6:0] O_FLUSH = 7'b1010100;
  localparam logic [6:0] O_MEMB  = 7'b0000001;

  typedef struct packed {
    logic       mb;
    logic       exv;
    logic       tk;
    logic       ld;
    logic [4:0] rd;
    logic       idv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } stim_t;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_taken;
  logic             mem_busy;
  logic             if_adv;
  logic             if_redirect;
  logic             if_stall;
  logic             id_hold;
  logic             id_flush;
  logic             ex_bubble;
  logic             all_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  hz_state_t        dbg_state;
  logic [6:0]       outs;

  logic [9:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_taken   (ex_taken),
    .mem_busy   (mem_busy),
    .if_adv     (if_adv),
    .if_redirect(if_redirect),
    .if_stall   (if_stall),
    .id_hold    (id_hold),
    .id_flush   (id_flush),
    .ex_bubble  (ex_bubble),
    .all_hold   (all_hold),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .dbg_state  (dbg_state)
  );

  assign outs = {if_adv, if_redirect, if_stall, id_hold, id_flush, ex_bubble, all_hold};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(logic mb, logic tk, logic ld, logic [4:0] rd,
                               logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2);
    stim_t s;
    s.mb  = mb;
    s.exv = tk | ld;
    s.tk  = tk;
    s.ld  = ld;
    s.rd  = rd;
    s.idv = 1'b1;
    s.rs1 = rs1;
    s.u1  = u1;
    s.rs2 = rs2;
    s.u2  = u2;
    return s;
  endfunction

  function automatic stim_t s_idle();
    return st(1'b0, 1'b0, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0,
              5'($urandom_range(0, 31)), 1'b0);
  endfunction

  // driver tasks
  task automatic apply(input stim_t s);
    mem_busy   = s.mb;
    ex_valid   = s.exv;
    ex_taken   = s.tk;
    ex_is_load = s.ld;
    ex_rd      = s.rd;
    id_valid   = s.idv;
    id_rs1     = s.rs1;
    id_use_rs1 = s.u1;
    id_rs2     = s.rs2;
    id_use_rs2 = s.u2;
  endtask

  task automatic drive(input stim_t s, input logic [9:0] e);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [9:0] got, want;
    stim_t rs[3];
    logic [9:0] re[3];
    rst_n = 1'b0;
    apply(s_idle());
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({dbg_state, outs, stall_cnt, flush_cnt} !== {IDLE, O_IDLE, {CNT_W{1'b0}}, {CNT_W{1'b0}}})
      $display("FAIL rst_hold: got state=%0d outs=%b stall=%0d flush=%0d want state=0 outs=%b 0 0",
               dbg_state, outs, stall_cnt, flush_cnt, O_IDLE);
    else n_pass++;
    // walk into MEMWAIT with a pending redirect
    rs[0] = s_idle();                                          re[0] = {IDLE, O_IDLE};
    rs[1] = st(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0); re[1] = {RUN, O_MEMB};
    rs[2] = rs[1];                                             re[2] = {MEMWAIT, O_MEMB};
    for (int i = 0; i < 3; i++) begin
      drive(rs[i], re[i]);
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL rst_seq%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({dbg_state, outs, stall_cnt, flush_cnt} !== {IDLE, O_IDLE, {CNT_W{1'b0}}, {CNT_W{1'b0}}})
      $display("FAIL rst_midwait: got state=%0d outs=%b stall=%0d flush=%0d want state=0 outs=%b 0 0",
               dbg_state, outs, stall_cnt, flush_cnt, O_IDLE);
    else n_pass++;
    rs[0] = s_idle(); re[0] = {IDLE, O_IDLE};
    rs[1] = s_idle(); re[1] = {RUN, O_RUN};
    rs[2] = s_idle(); re[2] = {RUN, O_RUN};
    for (int i = 0; i < 3; i++) begin
      drive(rs[i], re[i]);
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL rst_release%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
    end
    n_total++;
    if (flush_cnt !== '0) $display("FAIL rst_no_redirect: flush_cnt=%0d want 0", flush_cnt);
    else n_pass++;
  endtask

  task automatic test_load_use();
    logic [9:0] got, want;
    stim_t rs[8];
    logic [9:0] re[8];
    rs[0] = st(1'b0, 1'b0, 1'b1, 5'd5, 5'd9, 1'b1, 5'd5, 1'b1); re[0] = {RUN, O_LU};
    rs[1] = s_idle();                                          re[1] = {LOADUSE, O_RUN};
    rs[2] = s_idle();                                          re[2] = {RUN, O_RUN};
    rs[3] = st(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); re[3] = {RUN, O_RUN};
    rs[4] = s_idle();                                          re[4] = {RUN, O_RUN};
    rs[5] = st(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0); re[5] = {RUN, O_RUN};
    rs[6] = st(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1); re[6] = {RUN, O_LU};
    rs[7] = s_idle();                                          re[7] = {LOADUSE, O_RUN};
    for (int i = 0; i < 8; i++) begin
      drive(rs[i], re[i]);
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL lu_row%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if (stall_cnt !== CNT_W'(1)) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
        else n_pass++;
      end
    end
    exp_stall = 2;
  endtask

  task automatic test_taken();
    logic [9:0] got, want;
    stim_t rs[7];
    logic [9:0] re[7];
    rs[0] = s_idle();                                          re[0] = {RUN, O_RUN};
    rs[1] = st(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0); re[1] = {RUN, O_TK};
    rs[2] = rs[1];                                             re[2] = {FLUSH, O_FLUSH};
    rs[3] = s_idle();                                          re[3] = {RUN, O_RUN};
    rs[4] = st(1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0); re[4] = {RUN, O_TK};
    rs[5] = s_idle();                                          re[5] = {FLUSH, O_FLUSH};
    rs[6] = s_idle();                                          re[6] = {RUN, O_RUN};
    for (int i = 0; i < 7; i++) begin
      drive(rs[i], re[i]);
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL tk_row%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if (flush_cnt !== CNT_W'(1)) $display("FAIL tk_flush_cnt: got %0d want 1", flush_cnt);
        else n_pass++;
      end
    end
    exp_flush = 2;
    n_total++;
    if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall))
      $display("FAIL tk_counters: flush=%0d stall=%0d want %0d %0d",
               flush_cnt, stall_cnt, exp_flush, exp_stall);
    else n_pass++;
  endtask

  task automatic test_memwait();
    logic [9:0] got, want;
    stim_t rs[10];
    logic [9:0] re[10];
    stim_t c;
    c = st(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    rs[0] = c;                                                 re[0] = {RUN, O_MEMB};
    rs[1] = c;                                                 re[1] = {MEMWAIT, O_MEMB};
    rs[2] = c;                                                 re[2] = {MEMWAIT, O_MEMB};
    rs[3] = st(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0); re[3] = {MEMWAIT, O_TK};
    rs[4] = s_idle();                                          re[4] = {FLUSH, O_FLUSH};
    rs[5] = s_idle();                                          re[5] = {RUN, O_RUN};
    rs[6] = st(1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0); re[6] = {RUN, O_MEMB};
    rs[7] = rs[6];                                             re[7] = {MEMWAIT, O_MEMB};
    rs[8] = s_idle();                                          re[8] = {MEMWAIT, O_RUN};
    rs[9] = s_idle();                                          re[9] = {RUN, O_RUN};
    for (int i = 0; i < 10; i++) begin
      drive(rs[i], re[i]);
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL mw_row%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
      if (i == 5) begin
        n_total++;
        if (stall_cnt !== CNT_W'(exp_stall + 3) || flush_cnt !== CNT_W'(exp_flush + 1))
          $display("FAIL mw_combo_cnt: stall=%0d flush=%0d want %0d %0d",
                   stall_cnt, flush_cnt, exp_stall + 3, exp_flush + 1);
        else n_pass++;
      end
    end
    exp_stall = exp_stall + 5;
    exp_flush = exp_flush + 1;
    n_total++;
    if (stall_cnt !== CNT_W'(exp_stall)) $display("FAIL mw_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] got, want;
    stim_t rs[8];
    logic [9:0] re[8];
    rs[0] = st(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0); re[0] = {RUN, O_LU};
    rs[1] = st(1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1); re[1] = {LOADUSE, O_LU};
    rs[2] = s_idle();                                          re[2] = {LOADUSE, O_RUN};
    rs[3] = s_idle();                                          re[3] = {RUN, O_RUN};
    rs[4] = st(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b0); re[4] = {RUN, O_LU};
    rs[5] = st(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); re[5] = {LOADUSE, O_TK};
    rs[6] = s_idle();                                          re[6] = {FLUSH, O_FLUSH};
    rs[7] = s_idle();                                          re[7] = {RUN, O_RUN};
    for (int i = 0; i < 8; i++) begin
      drive(rs[i], re[i]);
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL b2b_row%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
    end
    exp_stall = exp_stall + 3;
    exp_flush = exp_flush + 1;
    n_total++;
    if (stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush))
      $display("FAIL b2b_counters: stall=%0d flush=%0d want %0d %0d",
               stall_cnt, flush_cnt, exp_stall, exp_flush);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [9:0] got, want;
    stim_t mb;
    mb = st(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    drive(s_idle(), {IDLE, O_IDLE});
    rst_n = 1'b1;
    // rows: IDLE, RUN(busy), 18 x MEMWAIT(busy), MEMWAIT(release), RUN
    for (int i = 0; i < 22; i++) begin
      if (i > 0) begin
        if (i == 1)       drive(mb, {RUN, O_MEMB});
        else if (i < 20)  drive(mb, {MEMWAIT, O_MEMB});
        else if (i == 20) drive(s_idle(), {MEMWAIT, O_RUN});
        else              drive(s_idle(), {RUN, O_RUN});
      end
      @(negedge clk);
      got  = {dbg_state, outs};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want)
        $display("FAIL sat_row%0d: got state=%0d outs=%b want state=%0d outs=%b",
                 i, got[9:7], got[6:0], want[9:7], want[6:0]);
      else n_pass++;
      if (i == 16) begin
        n_total++;
        if (stall_cnt !== CNT_MAX - 1'b1) $display("FAIL sat_max_m1: got %0d want %0d", stall_cnt, CNT_MAX - 1'b1);
        else n_pass++;
      end
      if (i == 19 || i == 21) begin
        n_total++;
        if (stall_cnt !== CNT_MAX) $display("FAIL sat_hold%0d: got %0d want %0d", i, stall_cnt, CNT_MAX);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_taken();
    test_memwait();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
